ram_block_ctrl: RTL and testbench
=================================

Name: ram_block_ctrl

Overview:
Sequencer and arbiter in front of one simple-dual-port block RAM (registered read, 1-cycle read latency, one write port). It shares the read port between a video pixel fetcher (r0) and a CPU/MMIO reader (r1), and forwards CPU writes. An internal fill engine can clear the whole RAM to a constant. All RAM port signals come from this block; the RAM instance has no other driver.

Parameters:
DATA_WIDTH, 12, RAM word width
ADDR_WIDTH, 15, RAM address width; depth = 2**ADDR_WIDTH
STARVE_LIMIT, 8, consecutive cycles r1 may wait while r0 is granted before r1 is forced through (1..255)

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  asynchronous, active-high reset
r0_req  in  1  video read request; hold req and addr stable until r0_gnt
r0_addr  in  ADDR_WIDTH  video read address
r0_gnt  out  1  video request accepted this cycle
r0_rvalid  out  1  r0_rdata valid; pulses 1 cycle after r0_gnt
r0_rdata  out  DATA_WIDTH  video read data
r1_req, r1_addr, r1_gnt, r1_rvalid, r1_rdata  same as r0_*, for the CPU reader
w_req  in  1  CPU write request
w_addr  in  ADDR_WIDTH  CPU write address
w_data  in  DATA_WIDTH  CPU write data
w_gnt  out  1  write performed this cycle
fill_start  in  1  1-cycle pulse: fill entire RAM with fill_value
fill_value  in  DATA_WIDTH  fill word, sampled on the accepted fill_start
fill_busy  out  1  fill in progress
fill_done  out  1  1-cycle pulse after the last fill write
ram_read_addr  out  ADDR_WIDTH  to RAM read_addr
ram_write_addr  out  ADDR_WIDTH  to RAM write_addr
ram_data  out  DATA_WIDTH  to RAM data
ram_we  out  1  to RAM we
ram_q  in  DATA_WIDTH  from RAM q

Behaviour:
- Reset (async): r*_rvalid=0, fill_busy=0, fill_done=0, starve_cnt=0, fill FSM in IDLE, fill_addr=0. While reset is high, all gnt outputs and ram_we are forced to 0.
- Read arbitration is combinational within the cycle. Default: r0 has strict priority. r0_gnt = r0_req & ~force1. r1_gnt = r1_req & (~r0_req | force1).
- force1 = (starve_cnt == STARVE_LIMIT).
- starve_cnt increments when r1_req & ~r1_gnt. It clears on r1_gnt or when r1_req=0. It saturates at STARVE_LIMIT.
- ram_read_addr = r1_addr when r1_gnt is high, otherwise r0_addr.
- Read latency: grant in cycle N gives rX_rvalid=1 in cycle N+1 (registered copy of rX_gnt). rX_rdata = ram_q combinationally; it is valid only while rX_rvalid is high. Back-to-back grants give one word per cycle.
- Write path, fill FSM in IDLE: w_gnt = w_req, ram_we = w_req, ram_write_addr = w_addr, ram_data = w_data.
- Fill FSM states are IDLE, FILL, DONE.
  - IDLE -> FILL on fill_start: latch fill_value, fill_addr=0, fill_busy=1.
  - FILL: ram_we=1, ram_write_addr=fill_addr, ram_data=latched value, fill_addr++ each cycle. w_gnt=0, so CPU writes stall with req held.
  - FILL -> DONE after writing address 2**ADDR_WIDTH-1. A fill takes exactly 2**ADDR_WIDTH cycles; fill_addr does not wrap.
  - DONE: fill_busy=0, fill_done=1 for one cycle, ram_we=0, then -> IDLE unconditionally.
  - fill_start is ignored in FILL and DONE.
  - A fill_start and w_req in the same IDLE cycle: the write is granted that cycle and the fill starts next cycle.
- Reads are unaffected by fill; they are arbitrated normally throughout.
- Read and write to the same address in the same cycle: the read returns the old contents (RAM read-before-write). No forwarding is done; this is the defined behaviour.
- Reset mid-fill: the fill aborts, the FSM goes to IDLE, partial contents remain, and no fill_done is issued. Any rvalid due in the cycle after reset is suppressed.

Decomposition:
- Package ram_ctrl_pkg holds the fill FSM state encoding (IDLE=2'd0, FILL=2'd1, DONE=2'd2) and requester index constants (REQ_VIDEO=0, REQ_CPU=1).
- Sub-module ram_fill_fsm contains the fill state machine, address counter, value latch, busy and done outputs. The top level holds the read arbiter, starvation counter, rvalid registers and the write mux.

Test Plan:
All scenarios use ADDR_WIDTH=4, DATA_WIDTH=12 and a real RAM model.
1. Latency: r0_req with addr 3 (RAM[3]=12'h0AB) -> r0_gnt same cycle; r0_rvalid=1 and r0_rdata=12'h0AB exactly 1 cycle later; r1_rvalid stays 0.
2. Priority: r0_req and r1_req both held high -> r0 granted 8 cycles, r1 granted in cycle 9 (r0_gnt=0 that cycle), starve_cnt returns to 0, pattern repeats.
3. Fill: fill_start with fill_value=12'h5A5 while w_req is held -> fill_busy high for 16 cycles, w_gnt=0 throughout, fill_done pulses once; w_gnt next cycle; all 16 reads return 12'h5A5 except the addr later written.
4. Collision: write 12'h111 to addr 7 (old 12'h222) while r1 reads addr 7 in the same cycle -> r1_rdata=12'h222; next read of addr 7 returns 12'h111.
5. Reset mid-fill: assert reset at fill_addr=5 -> fill_busy=0 immediately, no fill_done, addrs 0-4 hold the fill value, 5-15 keep old data; a new fill_start then runs the full 16 cycles.
6. Ignored start: second fill_start during FILL -> no restart; total busy stays 16 cycles.

Source files
------------

// File: rtl/ram_block_ctrl_pkg.sv
// ram_ctrl_pkg: constants shared by the block RAM controller.
//   - Fill state machine encoding (IDLE, FILL, DONE).
//   - Requester indices used for the read-grant and read-valid vectors.
package ram_ctrl_pkg;

  // Fill state machine encoding
  localparam logic [1:0] FILL_IDLE = 2'd0;
  localparam logic [1:0] FILL_FILL = 2'd1;
  localparam logic [1:0] FILL_DONE = 2'd2;

  // Requester indices into the read grant / valid vectors
  localparam int REQ_VIDEO = 0;
  localparam int REQ_CPU   = 1;

endpackage

// File: rtl/ram_block_ctrl_fill_fsm.sv
// ram_fill_fsm: walks the whole RAM address space once, writing a latched
// constant to every word.
// Ports:
//   clk, reset            system clock, async active-high reset
//   fill_start            1-cycle start pulse (only honoured while idle)
//   fill_value            fill word, captured on the accepted start
//   fill_busy, fill_done  status: busy during the sweep, done pulse after it
//   fill_idle             FSM is idle, so the CPU write path owns the RAM
//   fill_we, fill_addr,   write port request from the sweep
//   fill_data
module ram_fill_fsm
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fill_start,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic                  fill_idle,
  output logic                  fill_we,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  output logic [DATA_WIDTH-1:0] fill_data
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};

  logic [1:0]            state_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] value_r;
  logic                  busy_r;
  logic                  done_r;

  // Fill sequencing: start, one write per cycle, done pulse, back to idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= FILL_IDLE;
      addr_r  <= ADDR_ZERO;
      value_r <= {DATA_WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        FILL_IDLE: begin
          done_r <= 1'b0;
          if (fill_start) begin
            state_r <= FILL_FILL;
            addr_r  <= ADDR_ZERO;
            value_r <= fill_value;
            busy_r  <= 1'b1;
          end else begin
            state_r <= FILL_IDLE;
          end
        end
        FILL_FILL: begin
          // Address sticks at the last word; it never wraps back to zero.
          if (addr_r == ADDR_LAST) begin
            state_r <= FILL_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            addr_r <= addr_r + ADDR_ONE;
          end
        end
        FILL_DONE: begin
          state_r <= FILL_IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= FILL_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign fill_busy = busy_r;
  assign fill_done = done_r;
  assign fill_idle = (state_r == FILL_IDLE);
  assign fill_we   = (state_r == FILL_FILL);
  assign fill_addr = addr_r;
  assign fill_data = value_r;

endmodule

// File: rtl/ram_block_ctrl.sv
// ram_block_ctrl: arbiter/sequencer in front of a simple-dual-port block RAM
// with a registered (1-cycle) read port.
// Ports:
//   clk, reset                   system clock, async active-high reset
//   r0_* (video), r1_* (CPU)     read requesters: req/addr in, gnt/rvalid/rdata out
//   w_req, w_addr, w_data, w_gnt CPU write port
//   fill_start, fill_value,      whole-RAM fill engine control and status
//   fill_busy, fill_done
//   ram_read_addr, ram_write_addr, ram_data, ram_we, ram_q   RAM connection
module ram_block_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 12,
  parameter int ADDR_WIDTH   = 15,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  r0_req,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  output logic                  r0_gnt,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  input  logic                  r1_req,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  output logic                  r1_gnt,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  input  logic                  w_req,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_gnt,
  input  logic                  fill_start,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  logic [7:0]            starve_cnt_r;
  logic                  force1_s;
  logic [1:0]            rd_gnt_s;
  logic [1:0]            rvalid_r;
  logic                  fill_idle_s;
  logic                  fill_we_s;
  logic [ADDR_WIDTH-1:0] fill_addr_s;
  logic [DATA_WIDTH-1:0] fill_data_s;

  ram_fill_fsm #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_fill (
    .clk        (clk),
    .reset      (reset),
    .fill_start (fill_start),
    .fill_value (fill_value),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .fill_idle  (fill_idle_s),
    .fill_we    (fill_we_s),
    .fill_addr  (fill_addr_s),
    .fill_data  (fill_data_s)
  );

  // Read arbitration: video has strict priority unless the CPU has starved
  always_comb begin
    force1_s = (starve_cnt_r == STARVE_MAX);
    rd_gnt_s = 2'b00;
    if (reset) begin
      rd_gnt_s = 2'b00;
    end else begin
      rd_gnt_s[REQ_VIDEO] = r0_req & ~force1_s;
      rd_gnt_s[REQ_CPU]   = r1_req & (~r0_req | force1_s);
    end
    if (rd_gnt_s[REQ_CPU]) begin
      ram_read_addr = r1_addr;
    end else begin
      ram_read_addr = r0_addr;
    end
  end

  // Starvation counter: consecutive cycles the CPU reader waited, saturating
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_r <= 8'd0;
    end else if (r1_req & ~rd_gnt_s[REQ_CPU]) begin
      if (starve_cnt_r != STARVE_MAX) begin
        starve_cnt_r <= starve_cnt_r + 8'd1;
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end else begin
      starve_cnt_r <= 8'd0;
    end
  end

  // Read-valid pipeline matching the RAM's one-cycle read latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid_r <= 2'b00;
    end else begin
      rvalid_r <= rd_gnt_s;
    end
  end

  // Write port mux: fill sweep owns the port while active, CPU only when idle
  always_comb begin
    ram_we         = 1'b0;
    w_gnt          = 1'b0;
    ram_write_addr = w_addr;
    ram_data       = w_data;
    if (reset) begin
      ram_we = 1'b0;
      w_gnt  = 1'b0;
    end else if (fill_we_s) begin
      ram_we         = 1'b1;
      ram_write_addr = fill_addr_s;
      ram_data       = fill_data_s;
    end else if (fill_idle_s) begin
      ram_we = w_req;
      w_gnt  = w_req;
    end else begin
      // Done cycle: the port rests for one cycle before CPU writes resume.
      ram_we = 1'b0;
      w_gnt  = 1'b0;
    end
  end

  assign r0_gnt    = rd_gnt_s[REQ_VIDEO];
  assign r1_gnt    = rd_gnt_s[REQ_CPU];
  assign r0_rvalid = rvalid_r[REQ_VIDEO];
  assign r1_rvalid = rvalid_r[REQ_CPU];
  // Read data is shared; each requester qualifies it with its own rvalid.
  assign r0_rdata  = ram_q;
  assign r1_rdata  = ram_q;

endmodule

// File: tb/tb_ram_block_ctrl.sv
// Self-checking bench for ram_block_ctrl with a 16-word behavioural RAM.
module tb_ram_block_ctrl;

  localparam int DW    = 12;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int LIM   = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          r0_req, r1_req, w_req, fill_start;
  logic [AW-1:0] r0_addr, r1_addr, w_addr;
  logic [DW-1:0] w_data, fill_value;
  logic          r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, w_gnt;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic          fill_busy, fill_done;
  logic [AW-1:0] ram_read_addr, ram_write_addr;
  logic [DW-1:0] ram_data, ram_q;
  logic          ram_we;

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  ram_block_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_gnt(w_gnt),
    .fill_start(fill_start), .fill_value(fill_value), .fill_busy(fill_busy), .fill_done(fill_done),
    .ram_read_addr(ram_read_addr), .ram_write_addr(ram_write_addr), .ram_data(ram_data),
    .ram_we(ram_we), .ram_q(ram_q)
  );

  // Simple-dual-port RAM, registered read, read-before-write
  always @(posedge clk) begin
    if (ram_we) mem[ram_write_addr] <= ram_data;
    ram_q <= mem[ram_read_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    w_req = 1'b1; w_addr = a; w_data = d;
    @(negedge clk);
    chk("wr_gnt", {31'd0, w_gnt}, 32'd1);
    tick();
    w_req = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic rd(input int port, input logic [AW-1:0] a);
    logic [DW-1:0] e;
    e = ref_mem[a];
    if (port == 0) begin r0_req = 1'b1; r0_addr = a; end
    else begin r1_req = 1'b1; r1_addr = a; end
    @(negedge clk);
    chk("rd_gnt", {31'd0, (port == 0) ? r0_gnt : r1_gnt}, 32'd1);
    tick();
    r0_req = 1'b0; r1_req = 1'b0;
    @(negedge clk);
    chk("rd_rvalid", {31'd0, (port == 0) ? r0_rvalid : r1_rvalid}, 32'd1);
    chk("rd_rdata", {20'd0, (port == 0) ? r0_rdata : r1_rdata}, {20'd0, e});
    tick();
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) rd(i % 2, AW'(i));
  endtask

  // Counts busy cycles and done pulses for one fill started this cycle
  task automatic run_fill(input logic [DW-1:0] v, input int restart_k,
                          output int busy_n, output int done_n);
    fill_start = 1'b1; fill_value = v;
    tick();
    fill_start = 1'b0; fill_value = 12'h777;
    busy_n = 0; done_n = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (fill_busy) busy_n++;
      if (fill_done) done_n++;
      fill_start = (k == restart_k);
      tick();
    end
    fill_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = v;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int busy_n, done_n, done_k, wgnt_k, wgnt_busy, waited;
    logic h0, h1, e0, e1, p0, p1, done_seen;
    logic [DW-1:0] pd0, pd1, v;

    // ---- reset state, gating of grants while in reset
    reset = 1'b1;
    r0_req = 1'b1; r1_req = 1'b1; w_req = 1'b1; fill_start = 1'b0;
    r0_addr = 4'd0; r1_addr = 4'd0; w_addr = 4'd0; w_data = 12'd0; fill_value = 12'd0;
    tick(); tick();
    @(negedge clk);
    chk("rst_r0_gnt", {31'd0, r0_gnt}, 32'd0);
    chk("rst_r1_gnt", {31'd0, r1_gnt}, 32'd0);
    chk("rst_w_gnt", {31'd0, w_gnt}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_rvalid", {30'd0, r0_rvalid, r1_rvalid}, 32'd0);
    chk("rst_fill", {30'd0, fill_busy, fill_done}, 32'd0);
    tick();
    r0_req = 1'b0; r1_req = 1'b0; w_req = 1'b0;
    reset = 1'b0;
    tick();
    @(negedge clk);
    chk("post_rst_rvalid", {30'd0, r0_rvalid, r1_rvalid}, 32'd0);
    tick();

    // ---- preload through the CPU write port
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 3) v = 12'h0AB;
      else if (i == 7) v = 12'h222;
      else v = DW'($urandom_range(0, 4095));
      wr(AW'(i), v);
    end

    // ---- latency: grant same cycle, data exactly one cycle later
    r0_req = 1'b1; r0_addr = 4'd3;
    @(negedge clk);
    chk("lat_r0_gnt", {31'd0, r0_gnt}, 32'd1);
    chk("lat_r0_rvalid_early", {31'd0, r0_rvalid}, 32'd0);
    tick();
    r0_req = 1'b0;
    @(negedge clk);
    chk("lat_r0_rvalid", {31'd0, r0_rvalid}, 32'd1);
    chk("lat_r0_rdata", {20'd0, r0_rdata}, 32'h0AB);
    chk("lat_r1_rvalid", {31'd0, r1_rvalid}, 32'd0);
    tick();
    @(negedge clk);
    chk("lat_r0_rvalid_off", {31'd0, r0_rvalid}, 32'd0);
    tick();

    // ---- priority: both held, r1 forced through after LIM waiting cycles
    r0_req = 1'b1; r0_addr = 4'd1; r1_req = 1'b1; r1_addr = 4'd2;
    for (int c = 0; c < 2 * (LIM + 1); c++) begin
      @(negedge clk);
      chk("prio_r0_gnt", {31'd0, r0_gnt}, {31'd0, (c % (LIM + 1)) != LIM});
      chk("prio_r1_gnt", {31'd0, r1_gnt}, {31'd0, (c % (LIM + 1)) == LIM});
      tick();
    end
    r0_req = 1'b0; r1_req = 1'b0;
    tick(); tick();

    // ---- randomized reads against the arbitration rules and memory model
    h0 = 1'b0; h1 = 1'b0; p0 = 1'b0; p1 = 1'b0; pd0 = 12'd0; pd1 = 12'd0; waited = 0;
    for (int c = 0; c < 80; c++) begin
      if (!h0) begin r0_req = ($urandom_range(0, 3) != 0); r0_addr = AW'($urandom_range(0, 15)); end
      if (!h1) begin r1_req = ($urandom_range(0, 1) != 0); r1_addr = AW'($urandom_range(0, 15)); end
      e1 = r1_req && (!r0_req || waited >= LIM);
      e0 = r0_req && !e1;
      @(negedge clk);
      chk("rnd_r0_gnt", {31'd0, r0_gnt}, {31'd0, e0});
      chk("rnd_r1_gnt", {31'd0, r1_gnt}, {31'd0, e1});
      chk("rnd_r0_rvalid", {31'd0, r0_rvalid}, {31'd0, p0});
      chk("rnd_r1_rvalid", {31'd0, r1_rvalid}, {31'd0, p1});
      if (p0) chk("rnd_r0_rdata", {20'd0, r0_rdata}, {20'd0, pd0});
      if (p1) chk("rnd_r1_rdata", {20'd0, r1_rdata}, {20'd0, pd1});
      p0 = e0; pd0 = ref_mem[r0_addr];
      p1 = e1; pd1 = ref_mem[r1_addr];
      waited = (r1_req && !e1) ? ((waited < LIM) ? waited + 1 : LIM) : 0;
      h0 = r0_req && !e0;
      h1 = r1_req && !e1;
      tick();
    end
    r0_req = 1'b0; r1_req = 1'b0;
    tick(); tick();

    // ---- collision: read-before-write on the same address
    w_req = 1'b1; w_addr = 4'd7; w_data = 12'h111;
    r1_req = 1'b1; r1_addr = 4'd7;
    @(negedge clk);
    chk("col_w_gnt", {31'd0, w_gnt}, 32'd1);
    chk("col_r1_gnt", {31'd0, r1_gnt}, 32'd1);
    tick();
    w_req = 1'b0; r1_req = 1'b0;
    @(negedge clk);
    chk("col_r1_rvalid", {31'd0, r1_rvalid}, 32'd1);
    chk("col_old_data", {20'd0, r1_rdata}, 32'h222);
    tick();
    ref_mem[7] = 12'h111;
    rd(1, 4'd7);

    // ---- fill with a CPU write held, plus an ignored restart mid-fill
    w_req = 1'b1; w_addr = 4'd9; w_data = 12'hC3C;
    fill_start = 1'b1; fill_value = 12'h5A5;
    @(negedge clk);
    chk("fill_same_cycle_wgnt", {31'd0, w_gnt}, 32'd1);
    chk("fill_busy_before", {31'd0, fill_busy}, 32'd0);
    tick();
    fill_start = 1'b0; fill_value = 12'h777;
    busy_n = 0; done_n = 0; done_k = -1; wgnt_k = -1; wgnt_busy = 0;
    for (int k = 0; k < 40 && wgnt_k < 0; k++) begin
      @(negedge clk);
      if (fill_busy) busy_n++;
      if (fill_done) begin done_n++; done_k = k; end
      if (w_gnt) begin
        if (done_k < 0) wgnt_busy++;
        wgnt_k = k;
      end
      fill_start = (k == 4);
      tick();
    end
    w_req = 1'b0; fill_start = 1'b0;
    chk("fill_busy_cycles", 32'(busy_n), 32'd16);
    chk("fill_done_pulses", 32'(done_n), 32'd1);
    chk("fill_done_cycle", 32'(done_k), 32'd16);
    chk("fill_wgnt_while_busy", 32'(wgnt_busy), 32'd0);
    chk("fill_wgnt_after_done", 32'(wgnt_k), 32'd17);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 12'h5A5;
    ref_mem[9] = 12'hC3C;
    read_all();

    // ---- reset in the middle of a fill
    for (int i = 0; i < DEPTH; i++) begin
      v = DW'($urandom_range(0, 4095));
      if (v == 12'h3C3) v = 12'h3C2;
      wr(AW'(i), v);
    end
    fill_start = 1'b1; fill_value = 12'h3C3;
    tick();
    fill_start = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    #1;
    chk("rstfill_busy_now", {31'd0, fill_busy}, 32'd0);
    chk("rstfill_we_now", {31'd0, ram_we}, 32'd0);
    done_seen = fill_done;
    @(negedge clk); done_seen = done_seen | fill_done;
    tick();
    @(negedge clk); done_seen = done_seen | fill_done;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); done_seen = done_seen | fill_done;
      tick();
    end
    chk("rstfill_no_done", {31'd0, done_seen}, 32'd0);
    for (int i = 0; i < 5; i++) ref_mem[i] = 12'h3C3;
    read_all();

    // ---- a fresh fill after the abort runs the full length
    run_fill(12'h0F0, -1, busy_n, done_n);
    chk("refill_busy_cycles", 32'(busy_n), 32'd16);
    chk("refill_done_pulses", 32'(done_n), 32'd1);
    read_all();

    // ---- restart attempt during a fill is ignored
    run_fill(12'h9E1, 7, busy_n, done_n);
    chk("restart_busy_cycles", 32'(busy_n), 32'd16);
    chk("restart_done_pulses", 32'(done_n), 32'd1);
    rd(0, 4'd0);
    rd(1, 4'd15);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
